// File: rtl/instr_class_pkg.sv
// Shared codes for the MIPS instruction classifier: type/subclass
// encodings, opcode/funct constants and opcode group helpers.
package instr_class_pkg;

   localparam logic [1:0] TYPE_R   = 2'b00;
   localparam logic [1:0] TYPE_I   = 2'b01;
   localparam logic [1:0] TYPE_J   = 2'b10;
   localparam logic [1:0] TYPE_ILL = 2'b11;

   localparam logic [2:0] SUB_ALU     = 3'd0;
   localparam logic [2:0] SUB_ALUI    = 3'd1;
   localparam logic [2:0] SUB_LOAD    = 3'd2;
   localparam logic [2:0] SUB_STORE   = 3'd3;
   localparam logic [2:0] SUB_BRANCH  = 3'd4;
   localparam logic [2:0] SUB_JUMP    = 3'd5;
   localparam logic [2:0] SUB_LINK    = 3'd6;
   localparam logic [2:0] SUB_ILLEGAL = 3'd7;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_BLEZ  = 6'b000110;
   localparam logic [5:0] OP_BGTZ  = 6'b000111;
   localparam logic [5:0] OP_LB    = 6'b100000;
   localparam logic [5:0] OP_LH    = 6'b100001;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_LBU   = 6'b100100;
   localparam logic [5:0] OP_LHU   = 6'b100101;
   localparam logic [5:0] OP_SB    = 6'b101000;
   localparam logic [5:0] OP_SH    = 6'b101001;
   localparam logic [5:0] OP_SW    = 6'b101011;

   localparam logic [5:0] FN_JR   = 6'b001000;
   localparam logic [5:0] FN_JALR = 6'b001001;

   function automatic logic is_branch(input logic [5:0] op);
      return op inside {OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ};
   endfunction

   // Immediate ALU ops occupy the whole 001xxx opcode block.
   function automatic logic is_alui(input logic [5:0] op);
      return op[5:3] == 3'b001;
   endfunction

   function automatic logic is_load(input logic [5:0] op);
      return op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
   endfunction

   function automatic logic is_store(input logic [5:0] op);
      return op inside {OP_SB, OP_SH, OP_SW};
   endfunction

endpackage

// File: rtl/instr_class_dec.sv
// Combinational MIPS classifier: instruction word -> major type and
// subclass. Shared with the single-cycle datapaths.
module instr_class_dec
   import instr_class_pkg::*;
(
   input  logic [31:0] instr,
   output logic [1:0]  itype,
   output logic [2:0]  sub
);

   logic [5:0] op;
   logic [5:0] funct;
   logic       unused_bits;

   assign op          = instr[31:26];
   assign funct       = instr[5:0];
   assign unused_bits = ^instr[25:6];

   always_comb begin
      itype = TYPE_ILL;
      sub   = SUB_ILLEGAL;
      unique case (1'b1)
         op == OP_RTYPE: begin
            itype = TYPE_R;
            if (funct == FN_JR)
               sub = SUB_JUMP;
            else if (funct == FN_JALR)
               sub = SUB_LINK;
            else
               sub = SUB_ALU;
         end
         op == OP_J: begin
            itype = TYPE_J;
            sub   = SUB_JUMP;
         end
         op == OP_JAL: begin
            itype = TYPE_J;
            sub   = SUB_LINK;
         end
         is_branch(op): begin
            itype = TYPE_I;
            sub   = SUB_BRANCH;
         end
         is_alui(op): begin
            itype = TYPE_I;
            sub   = SUB_ALUI;
         end
         is_load(op): begin
            itype = TYPE_I;
            sub   = SUB_LOAD;
         end
         is_store(op): begin
            itype = TYPE_I;
            sub   = SUB_STORE;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/instr_class_pipe.sv
// Registered, valid/ready instruction classifier with per-type
// saturating occurrence counters for profiling.
module instr_class_pipe
   import instr_class_pkg::*;
#(
   parameter int CNT_WIDTH = 16,
   parameter int XLEN      = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [XLEN-1:0]      instr,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [XLEN-1:0]      out_instr,
   output logic [1:0]           out_type,
   output logic [2:0]           out_sub,
   input  logic                 clr_cnt,
   input  logic [1:0]           cnt_sel,
   output logic [CNT_WIDTH-1:0] cnt_val
);

   logic [1:0]           dec_type;
   logic [2:0]           dec_sub;
   logic                 xfer;
   logic                 hand;
   logic [CNT_WIDTH-1:0] cnt [4];

   instr_class_dec u_dec (
      .instr (instr[31:0]),
      .itype (dec_type),
      .sub   (dec_sub)
   );

   assign in_ready = !out_valid || out_ready;
   assign xfer     = in_valid && in_ready;
   assign hand     = out_valid && out_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_instr <= '0;
         out_type  <= TYPE_ILL;
         out_sub   <= SUB_ILLEGAL;
      end else if (xfer) begin
         out_valid <= 1'b1;
         out_instr <= instr;
         out_type  <= dec_type;
         out_sub   <= dec_sub;
      end else if (hand) begin
         out_valid <= 1'b0;
      end
   end

   // Counted on handoff so stalled results are not counted twice.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 4; i++)
            cnt[i] <= '0;
      end else if (clr_cnt) begin
         for (int i = 0; i < 4; i++)
            cnt[i] <= '0;
      end else if (hand && cnt[out_type] != '1) begin
         cnt[out_type] <= cnt[out_type] + 1'b1;
      end
   end

   assign cnt_val = cnt[cnt_sel];

endmodule
